// File: rtl/cpu_ctrl_unit_if.sv
// Memory-side bus of the CPU control unit: request/write/address-select outward, ready back.
interface cpu_ctrl_unit_if;
    // mem_req is held high until the cycle mem_ready is seen high; that cycle completes the access.
    logic mem_req;
    logic mem_we;
    logic mem_addr_sel;
    logic mem_ready;

    modport master (output mem_req, output mem_we, output mem_addr_sel, input mem_ready);
    modport slave  (input mem_req, input mem_we, input mem_addr_sel, output mem_ready);
endinterface

// File: rtl/cpu_ctrl_unit.sv
// Multi-cycle CPU control FSM: FETCH, DECODE, EXEC, MEM, WB, HALT with a memory wait timeout.
// Build option: CPU_CTRL_ILLEGAL_TRAP_EN halts on an unclassified or system instruction instead of NOP.
module cpu_ctrl_unit #(
    parameter int MEM_TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   inst_lui,
    input  logic                   inst_auipc,
    input  logic                   inst_jal,
    input  logic                   inst_jalr,
    input  logic                   inst_branch,
    input  logic                   inst_load,
    input  logic                   inst_store,
    input  logic                   inst_arlog_imm,
    input  logic                   inst_arlog,
    input  logic                   inst_misc_mem,
    input  logic                   inst_system,
    input  logic                   br_cond,
    cpu_ctrl_unit_if.master        mem,
    output logic                   ir_wr,
    output logic                   pc_wr,
    output logic [1:0]             pc_sel,
    output logic                   rf_wr,
    output logic [1:0]             rf_src,
    output logic                   alu_a_sel,
    output logic                   alu_b_sel,
    output logic                   halted,
    output logic                   bus_err,
    output logic [2:0]             dbg_state
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] LIMIT = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t          state;
    logic [CW-1:0]   wait_cnt;
    logic            timeout_hit;
    logic            illegal;
    logic            mem_op;
    logic            rf_class;

    // Last permitted wait cycle: mem_ready still wins if it arrives here.
    assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt == LIMIT);
    assign illegal  = ~|{inst_lui, inst_auipc, inst_jal, inst_jalr, inst_branch, inst_load,
                         inst_store, inst_arlog_imm, inst_arlog, inst_misc_mem, inst_system}
                      | inst_system;
    assign mem_op   = inst_load | inst_store;
    assign rf_class = inst_lui | inst_auipc | inst_jal | inst_jalr | inst_load
                      | inst_arlog | inst_arlog_imm;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= FETCH;
            wait_cnt <= '0;
            bus_err  <= 1'b0;
        end else begin
            case (state)
                FETCH, MEM: begin
                    if (mem.mem_ready) begin
                        state <= (state == FETCH) ? DECODE : WB;
                    end else if (timeout_hit) begin
                        state   <= HALT;
                        bus_err <= 1'b1;
                    end else if (MEM_TIMEOUT != 0) begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                DECODE: begin
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
                    state <= illegal ? HALT : EXEC;
`else
                    state <= EXEC;
`endif
                end
                EXEC: begin
                    wait_cnt <= '0;
                    state    <= (mem_op && !illegal) ? MEM : WB;
                end
                WB: begin
                    wait_cnt <= '0;
                    state    <= FETCH;
                end
                default: state <= HALT;
            endcase
        end
    end

    always_comb begin
        ir_wr            = 1'b0;
        pc_wr            = 1'b0;
        pc_sel           = 2'd0;
        rf_wr            = 1'b0;
        rf_src           = 2'd0;
        alu_a_sel        = 1'b0;
        alu_b_sel        = 1'b0;
        mem.mem_req      = 1'b0;
        mem.mem_we       = 1'b0;
        mem.mem_addr_sel = 1'b0;
        halted           = (state == HALT);
        dbg_state        = state;
        case (state)
            FETCH: begin
                mem.mem_req = 1'b1;
                ir_wr       = mem.mem_ready;
            end
            EXEC: begin
                alu_a_sel = inst_auipc;
                alu_b_sel = inst_arlog_imm | inst_load | inst_store | inst_jalr | inst_auipc;
            end
            MEM: begin
                mem.mem_req      = 1'b1;
                mem.mem_addr_sel = 1'b1;
                mem.mem_we       = inst_store;
            end
            WB: begin
                pc_wr = 1'b1;
                if (!illegal) begin
                    if (inst_jalr)                              pc_sel = 2'd2;
                    else if (inst_jal || (inst_branch && br_cond)) pc_sel = 2'd1;
                    rf_wr = rf_class;
                    if (inst_lui)                   rf_src = 2'd3;
                    else if (inst_load)             rf_src = 2'd1;
                    else if (inst_jal || inst_jalr) rf_src = 2'd2;
                end
            end
            default: ;
        endcase
        // Synchronous reset still silences every strobe in the reset cycle itself.
        if (!rst_n) begin
            ir_wr       = 1'b0;
            pc_wr       = 1'b0;
            rf_wr       = 1'b0;
            mem.mem_req = 1'b0;
            mem.mem_we  = 1'b0;
        end
    end

endmodule

// File: tb/tb_cpu_ctrl_unit.sv
// Self-checking bench for cpu_ctrl_unit: per-instruction expected output traces from the instruction rules.
module tb_cpu_ctrl_unit;

    localparam int TO = 4;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    localparam int C_LUI = 0, C_AUIPC = 1, C_JAL = 2, C_JALR = 3, C_BRANCH = 4, C_LOAD = 5;
    localparam int C_STORE = 6, C_ARLOG_IMM = 7, C_ARLOG = 8, C_MISC = 9, C_SYSTEM = 10, C_NONE = 11;
    // Strobe bits of the observed vector: ir_wr, pc_wr, rf_wr, mem_req, mem_we.
    localparam logic [13:0] STROBES = 14'b11_00_1_00_00_1_1_0_00;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [10:0] flags = '0;
    logic br_cond = 1'b0;
    logic ir_wr, pc_wr, rf_wr, alu_a_sel, alu_b_sel, halted, bus_err;
    logic [1:0] pc_sel, rf_src;
    logic [2:0] dbg_state;
    logic [13:0] obs;

    int checks = 0;
    int failures = 0;
    logic [13:0] exp_q[$];
    bit rdy_q[$];
    bit will_halt;

    cpu_ctrl_unit_if bus();

    cpu_ctrl_unit #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .inst_lui(flags[C_LUI]), .inst_auipc(flags[C_AUIPC]), .inst_jal(flags[C_JAL]),
        .inst_jalr(flags[C_JALR]), .inst_branch(flags[C_BRANCH]), .inst_load(flags[C_LOAD]),
        .inst_store(flags[C_STORE]), .inst_arlog_imm(flags[C_ARLOG_IMM]),
        .inst_arlog(flags[C_ARLOG]), .inst_misc_mem(flags[C_MISC]),
        .inst_system(flags[C_SYSTEM]), .br_cond(br_cond), .mem(bus),
        .ir_wr(ir_wr), .pc_wr(pc_wr), .pc_sel(pc_sel), .rf_wr(rf_wr), .rf_src(rf_src),
        .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .halted(halted), .bus_err(bus_err),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    assign obs = {ir_wr, pc_wr, pc_sel, rf_wr, rf_src, alu_a_sel, alu_b_sel,
                  bus.mem_req, bus.mem_we, bus.mem_addr_sel, halted, bus_err};

    task automatic check(input string tag, input logic [13:0] got, input logic [13:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b (ir pcw pcs rfw rfs a b req we as halt err)", tag, got, exp);
        end
    endtask

    function automatic logic [13:0] mk(bit ir, bit pcw, logic [1:0] pcs, bit rfw, logic [1:0] rfs,
                                       bit a, bit b, bit req, bit we, bit as_, bit h, bit e);
        return {ir, pcw, pcs, rfw, rfs, a, b, req, we, as_, h, e};
    endfunction

    function automatic bit rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input logic [13:0] v, input bit rdy);
        exp_q.push_back(v);
        rdy_q.push_back(rdy);
    endtask

    task automatic push_halt(input bit err);
        for (int i = 0; i < 3; i++) push(mk(0,0,0,0,0,0,0,0,0,0,1,err), rnd_bit());
        will_halt = 1'b1;
    endtask

    // Expected cycle-by-cycle trace of one instruction, straight from the instruction-class rules.
    task automatic build_plan(input int cls, input bit br, input int wf, input int wm);
        bit is_ill, is_mem, wr;
        logic [1:0] pcs, rfs;
        will_halt = 1'b0;
        is_ill = (cls == C_NONE) || (cls == C_SYSTEM);
        is_mem = (cls == C_LOAD) || (cls == C_STORE);
        if (wf >= TO) begin
            for (int i = 0; i < TO; i++) push(mk(0,0,0,0,0,0,0,1,0,0,0,0), 1'b0);
            push_halt(1'b1);
            return;
        end
        for (int i = 0; i < wf; i++) push(mk(0,0,0,0,0,0,0,1,0,0,0,0), 1'b0);
        push(mk(1,0,0,0,0,0,0,1,0,0,0,0), 1'b1);
        push(mk(0,0,0,0,0,0,0,0,0,0,0,0), rnd_bit());
        if (is_ill && TRAP) begin
            push_halt(1'b0);
            return;
        end
        push(mk(0,0,0,0,0, cls == C_AUIPC,
                cls inside {C_ARLOG_IMM, C_LOAD, C_STORE, C_JALR, C_AUIPC},
                0,0,0,0,0), rnd_bit());
        if (is_mem) begin
            if (wm >= TO) begin
                for (int i = 0; i < TO; i++) push(mk(0,0,0,0,0,0,0,1,cls == C_STORE,1,0,0), 1'b0);
                push_halt(1'b1);
                return;
            end
            for (int i = 0; i < wm; i++) push(mk(0,0,0,0,0,0,0,1,cls == C_STORE,1,0,0), 1'b0);
            push(mk(0,0,0,0,0,0,0,1,cls == C_STORE,1,0,0), 1'b1);
        end
        pcs = (cls == C_JALR) ? 2'd2 : ((cls == C_JAL) || (cls == C_BRANCH && br)) ? 2'd1 : 2'd0;
        wr  = cls inside {C_LUI, C_AUIPC, C_JAL, C_JALR, C_LOAD, C_ARLOG, C_ARLOG_IMM};
        rfs = (cls == C_LUI) ? 2'd3 : (cls == C_LOAD) ? 2'd1 :
              (cls == C_JAL || cls == C_JALR) ? 2'd2 : 2'd0;
        push(mk(0,1,pcs,wr,rfs,0,0,0,0,0,0,0), rnd_bit());
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.mem_ready = rnd_bit();
        @(negedge clk);
        check("reset_strobes", obs & STROBES, 14'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic run_inst(input int cls, input bit br, input int wf, input int wm, input int abort_n);
        int n, k;
        string tag;
        flags = (cls < C_NONE) ? (11'd1 << cls) : 11'd0;
        br_cond = br;
        build_plan(cls, br, wf, wm);
        n = (abort_n > 0) ? abort_n : exp_q.size();
        for (k = 0; k < n; k++) begin
            bus.mem_ready = rdy_q.pop_front();
            @(negedge clk);
            tag = $sformatf("cls%0d_br%0d_wf%0d_wm%0d_cyc%0d", cls, br, wf, wm, k + 1);
            check(tag, obs, exp_q.pop_front());
            @(posedge clk);
            #1;
        end
        exp_q.delete();
        rdy_q.delete();
        if (will_halt || abort_n > 0) do_reset();
    endtask

    initial begin
        bus.mem_ready = 1'b0;
        do_reset();
        run_inst(C_ARLOG, 0, 0, 0, 0);
        run_inst(C_LOAD, 0, 0, 3, 0);
        run_inst(C_BRANCH, 1, 0, 0, 0);
        run_inst(C_BRANCH, 0, 1, 0, 0);
        run_inst(C_JAL, 0, 2, 0, 0);
        run_inst(C_JALR, 1, 0, 0, 0);
        run_inst(C_LUI, 0, 0, 0, 0);
        run_inst(C_AUIPC, 0, 1, 0, 0);
        run_inst(C_STORE, 0, 0, 1, 0);
        run_inst(C_MISC, 0, 0, 0, 0);
        run_inst(C_ARLOG_IMM, 0, 0, 0, 0);
        run_inst(C_NONE, 0, 0, 0, 0);
        run_inst(C_SYSTEM, 1, 0, 0, 0);
        run_inst(C_ARLOG, 0, TO, 0, 0);
        run_inst(C_ARLOG, 0, TO - 1, 0, 0);
        run_inst(C_LOAD, 0, 0, TO, 0);
        run_inst(C_STORE, 0, 0, TO - 1, 0);
        run_inst(C_STORE, 0, 0, 3, 4);
        run_inst(C_ARLOG, 0, 0, 0, 0);
        for (int i = 0; i < 200; i++) begin
            int cls, wf, wm;
            cls = $urandom_range(0, 11);
            wf = ($urandom_range(0, 15) == 0) ? TO : $urandom_range(0, TO - 1);
            wm = ($urandom_range(0, 15) == 0) ? TO : $urandom_range(0, TO - 1);
            run_inst(cls, rnd_bit(), wf, wm, 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
